// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control sequencer for the stopwatch digit counter. Three raw push buttons
// are synchronised, debounced and edge-detected. The resulting press events
// drive a start/pause/lap/clear state machine, which generates the count-enable
// tick and the clear pulse for the digit counter.
//
// Ports:
//   clk             in   system clock, all logic on the rising edge
//   reset           in   synchronous, active-high reset
//   btn_start_stop  in   raw start/stop button (asynchronous, bouncy)
//   btn_lap         in   raw lap button (asynchronous, bouncy)
//   btn_clear       in   raw clear button (asynchronous, bouncy)
//   count_en        out  one-cycle tick, digit counter advances by one
//   count_clr       out  one-cycle pulse, digit counter returns to zero
//   running         out  high while the stopwatch is counting (RUN or LAP)
//   lap_hold        out  high in LAP; display freezes, counting continues
//
// Parameters:
//   CLK_HZ           system clock frequency in Hz
//   TICK_HZ          count_en rate in Hz; CLK_HZ/TICK_HZ must be exact and >= 2
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a new level; >= 2
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_lap,
  input  logic btn_clear,
  output logic count_en,
  output logic count_clr,
  output logic running,
  output logic lap_hold
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button lane indices inside the packed per-button vectors.
  localparam int B_SS    = 0;
  localparam int B_LAP   = 1;
  localparam int B_CLEAR = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning state
  // ---------------------------------------------------------------------------
  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       db_q, db_d;
  logic [2:0]       db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  logic [2:0]       press;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             count_en_q, count_en_d;
  logic             count_clr_q, count_clr_d;
  logic             running_q, running_d;
  logic             lap_hold_q, lap_hold_d;

  assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

  // ---------------------------------------------------------------------------
  // Synchronizer, debounce and press detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        // Level agrees with the accepted one: any bounce restarts the count.
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_MAX) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Press event on the debounced rising edge only; releases are ignored and a
  // held button yields a single event.
  assign press = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------
  // State machine, prescaler and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;

    // Within a state, clear outranks start/stop, which outranks lap.
    unique case (state_q)
      S_IDLE: begin
        if (press[B_CLEAR]) begin
          count_clr_d = 1'b1;
        end else if (press[B_SS]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (press[B_SS]) begin
          state_d = S_PAUSE;
        end else if (press[B_LAP]) begin
          state_d = S_LAP;
        end
      end
      S_LAP: begin
        if (press[B_SS]) begin
          state_d = S_PAUSE;
        end else if (press[B_LAP]) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (press[B_CLEAR]) begin
          count_clr_d = 1'b1;
          state_d     = S_IDLE;
        end else if (press[B_SS]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Prescaler follows the current state, so a pause holds the sub-tick
    // phase and leaving IDLE always starts from a fresh period.
    presc_d = presc_q;
    unique case (state_q)
      S_RUN, S_LAP: presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      S_PAUSE:      presc_d = presc_q;
      default:      presc_d = '0;
    endcase

    // Tick is decided on the pre-transition state: a pause landing on the
    // wrap cycle still issues that tick.
    count_en_d = ((state_q == S_RUN) || (state_q == S_LAP)) && (presc_q == PRESC_MAX);

    running_d  = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d = (state_d == S_LAP);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of the others, independent of statement order.
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      // NOTE: the debounce counters are plain flops, not a memory, so they are
      // reset alongside everything else; a stale count would shorten the next
      // debounce window after reset.
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q     <= S_IDLE;
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      running_q   <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      running_q   <= running_d;
      lap_hold_q  <= lap_hold_d;
    end
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign running   = running_q;
  assign lap_hold  = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10) and
// DEBOUNCE_CYCLES=4. Inputs change on the falling edge, so a value driven there
// is sampled at the next rising edge ("edge 0" of a step); outputs are read on
// the falling edge, reflecting the rising edge just before. With DEBOUNCE=4 a
// press sampled at edge k updates the state machine at edge k+6.
// Edge numbers in comments count rising edges from the first driven step.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_start_stop = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;
  logic count_en;
  logic count_clr;
  logic running;
  logic lap_hold;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .running        (running),
    .lap_hold       (lap_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " count_en"},  int'(count_en),  0);
    check({tag, " count_clr"}, int'(count_clr), 0);
    check({tag, " running"},   int'(running),   0);
    check({tag, " lap_hold"},  int'(lap_hold),  0);
  endtask

  int ticks;
  int run_low;
  int run_high;
  int doubles;
  int clrs;
  logic prev_en;

  initial begin
    // ---------------- reset state ----------------
    cycles(3);
    check_outputs_zero("reset");
    reset = 1'b0;

    // ---------------- bounce rejection ----------------
    // 3 high, 1 low, 3 high, low: never 4 stable cycles, so no press.
    btn_start_stop = 1'b1; cycles(3);
    btn_start_stop = 1'b0; cycles(1);
    btn_start_stop = 1'b1; cycles(3);
    btn_start_stop = 1'b0;
    run_high = 0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (running) run_high++;
      if (count_en) ticks++;
    end
    check("bounce running cycles", run_high, 0);
    check("bounce ticks", ticks, 0);

    // ---------------- clean start ----------------
    btn_start_stop = 1'b1;               // sampled at edge 0
    cycles(6);  check("start running@5", int'(running), 0);
    cycles(1);  check("start running@6", int'(running), 1);
    cycles(9);  check("start count_en@15", int'(count_en), 0);
    cycles(1);  check("start count_en@16", int'(count_en), 1);
    cycles(1);  check("start count_en@17", int'(count_en), 0);
    cycles(9);  check("start count_en@26", int'(count_en), 1);
    cycles(10); check("start count_en@36", int'(count_en), 1);

    // Button still held: 100 more cycles, one tick per 10, state unchanged.
    ticks = 0; run_low = 0; doubles = 0; prev_en = count_en;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (count_en) ticks++;
      if (!running) run_low++;
      if (count_en && prev_en) doubles++;
      prev_en = count_en;
    end
    check("held ticks", ticks, 10);
    check("held running low cycles", run_low, 0);
    check("held back-to-back ticks", doubles, 0);

    // ---------------- pause / resume phase ----------------
    btn_start_stop = 1'b0;               // released, edge 137
    cycles(17);                          // after edge 153
    btn_start_stop = 1'b1;               // press sampled 154 -> PAUSE at 160
    cycles(2);  check("pause count_en@155", int'(count_en), 0);
    cycles(1);  check("pause count_en@156", int'(count_en), 1);
    cycles(3);  check("pause running@159", int'(running), 1);
    cycles(1);  check("pause running@160", int'(running), 0);
    btn_start_stop = 1'b0;
    ticks = 0; run_high = 0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (count_en) ticks++;
      if (running) run_high++;
    end
    check("paused ticks", ticks, 0);
    check("paused running cycles", run_high, 0);
    btn_start_stop = 1'b1;               // sampled 211 -> RUN at 217
    cycles(6);  check("resume running@216", int'(running), 0);
    cycles(1);  check("resume running@217", int'(running), 1);
    cycles(5);  check("resume count_en@222", int'(count_en), 0);
    cycles(1);  check("resume count_en@223", int'(count_en), 1);
    btn_start_stop = 1'b0;

    // ---------------- lap ----------------
    cycles(6);
    btn_lap = 1'b1;                      // sampled 230 -> LAP at 236
    cycles(6);  check("lap lap_hold@235", int'(lap_hold), 0);
    cycles(1);  check("lap lap_hold@236", int'(lap_hold), 1);
                check("lap running@236", int'(running), 1);
    btn_lap = 1'b0;
    cycles(7);  check("lap count_en@243", int'(count_en), 1);
    cycles(10); check("lap count_en@253", int'(count_en), 1);
                check("lap lap_hold@253", int'(lap_hold), 1);
    btn_lap = 1'b1;                      // sampled 254 -> RUN at 260
    cycles(7);  check("lap2 lap_hold@260", int'(lap_hold), 0);
                check("lap2 running@260", int'(running), 1);
    btn_lap = 1'b0;
    cycles(7);
    btn_lap = 1'b1;                      // sampled 268 -> LAP at 274
    cycles(7);  check("lap3 lap_hold@274", int'(lap_hold), 1);
    btn_lap = 1'b0;
    btn_start_stop = 1'b1;               // sampled 275 -> PAUSE at 281
    cycles(7);  check("lap->pause lap_hold@281", int'(lap_hold), 0);
                check("lap->pause running@281", int'(running), 0);
    cycles(2);  check("lap->pause count_en@283", int'(count_en), 0);
    btn_start_stop = 1'b0;

    // ---------------- clear priority in PAUSE ----------------
    cycles(6);
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;               // sampled 290 -> clear at 296
    cycles(6);  check("clr count_clr@295", int'(count_clr), 0);
    cycles(1);  check("clr count_clr@296", int'(count_clr), 1);
                check("clr running@296", int'(running), 0);
    cycles(1);  check("clr count_clr@297", int'(count_clr), 0);
                check("clr running@297", int'(running), 0);
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;

    // ---------------- clear ignored in RUN ----------------
    cycles(6);
    btn_start_stop = 1'b1;               // sampled 304 -> RUN at 310
    cycles(7);  check("run2 running@310", int'(running), 1);
    btn_start_stop = 1'b0;
    btn_clear = 1'b1;                    // sampled 311 -> ignored at 317
    clrs = 0; run_low = 0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (count_clr) clrs++;
      if (!running) run_low++;
      if (count_en) ticks++;
    end
    check("run clear count_clr pulses", clrs, 0);
    check("run clear running low cycles", run_low, 0);
    check("run2 ticks 311..320", ticks, 1);
    check("run2 count_en@320", int'(count_en), 1);
    btn_clear = 1'b0;

    // ---------------- reset mid-run ----------------
    cycles(7);                           // prescaler = 7 after edge 327
    reset = 1'b1;
    cycles(1);
    check_outputs_zero("midrun reset");
    reset = 1'b0;
    ticks = 0; run_high = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (count_en) ticks++;
      if (running) run_high++;
    end
    check("post-reset ticks", ticks, 0);
    check("post-reset running cycles", run_high, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control sequencer for the stopwatch digit counter.
- Conditions three raw Basys3 buttons (start/stop, lap, clear): 2-flop synchronizer, debounce and press-edge detection per button.
- Runs a start/pause/lap/clear state machine and generates the 100 Hz count-enable tick and a clear pulse for the counter.
- Drives running/lap-hold status to the display path.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count_en rate in Hz. DIV = CLK_HZ/TICK_HZ; must divide exactly; DIV >= 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a new button level (10 ms at 100 MHz); >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_start_stop  input  1  raw start/stop button, asynchronous, bouncy, active-high.
- btn_lap  input  1  raw lap button, same properties.
- btn_clear  input  1  raw clear button, same properties.
- count_en  output  1  one-cycle tick to the digit counter; advance by one when high.
- count_clr  output  1  one-cycle pulse; digit counter returns to zero.
- running  output  1  high in RUN or LAP.
- lap_hold  output  1  high in LAP; display freezes its latched value, counting continues.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset, sampled at a clk edge while high:
  - state = IDLE; prescaler = 0.
  - Synchronizer flops, debounced levels, debounce counters and press pulses all 0.
  - All outputs 0.
- All outputs are registered.
- Synchronizer: two flops per button; s = second-flop output.
- Debounce, per button, counter width $clog2(DEBOUNCE_CYCLES):
  - s == db: cnt <= 0.
  - s != db: cnt <= cnt+1.
  - At cnt == DEBOUNCE_CYCLES-1 with s != db: db <= s, cnt <= 0.
  - Any bounce back to db restarts the count.
- Press event: one-cycle pulse on db rising (db_prev registered). Releases generate nothing.
- Latency: clean raw rise sampled at edge k gives:
  - s high after edge k+1.
  - db high after edge k+1+DEBOUNCE_CYCLES.
  - FSM/output update at edge k+2+DEBOUNCE_CYCLES.
- FSM states and transitions. Within a state, simultaneous presses resolve clear > start_stop > lap.
  - IDLE:
    - clear: count_clr pulse, stay IDLE.
    - start_stop: go to RUN.
    - lap: ignored.
  - RUN:
    - start_stop: go to PAUSE.
    - lap: go to LAP.
    - clear: ignored.
  - LAP:
    - lap: go to RUN (display live again).
    - start_stop: go to PAUSE; lap_hold drops.
    - clear: ignored.
  - PAUSE:
    - clear: count_clr pulse, go to IDLE.
    - start_stop: go to RUN.
    - lap: ignored.
- Prescaler, width $clog2(DIV):
  - RUN/LAP: increments; wraps DIV-1 -> 0.
  - PAUSE: holds, so resume keeps sub-tick phase.
  - IDLE: forced to 0.
- count_en <= (state is RUN or LAP) && prescaler == DIV-1. Exactly one pulse per DIV cycles, never two consecutive cycles.
- Entering RUN from IDLE: first count_en appears DIV cycles after the edge that entered RUN.
- Transition into PAUSE in the same cycle prescaler == DIV-1: the tick is still issued, because it is decided on the pre-transition state.
- count_clr is asserted the cycle after the clear press is accepted; width exactly one cycle.
- Reset mid-operation (any state, any debounce progress): everything returns to reset values at that edge, including any in-flight tick or count_clr.
- Held button: produces exactly one press event.

Test Plan:
- Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYCLES=4.
- Clean start: raise btn_start_stop at edge 0 and hold.
  - running=1 at edge 6.
  - count_en high at edges 16, 26, 36, each for one cycle.
  - Holding the button 100 cycles produces no further state change.
- Bounce rejection: btn_start_stop pulses high for 3 cycles, low for 1, high 3, low.
  - No press event; state stays IDLE; running=0.
- Pause/resume phase: pause after 4 post-tick cycles, wait 50 cycles, resume.
  - No count_en during PAUSE.
  - First tick after resume arrives 6 cycles after re-entering RUN.
- Lap: in RUN, press lap.
  - lap_hold=1, running=1, count_en continues every 10 cycles.
  - Press lap again: lap_hold=0.
  - Press start_stop from LAP: PAUSE, lap_hold=0.
- Clear priority: in PAUSE, press clear and start_stop together.
  - count_clr high exactly 1 cycle; state IDLE.
  - Clear pressed in RUN: count_clr stays 0.
- Reset mid-run: assert reset for 1 cycle in RUN with prescaler=7.
  - All outputs 0 next cycle.
  - No count_en for the following 20 cycles without a new press.
